program_sequencer: RTL and testbench



---
 rtl/program_sequencer_pkg.sv | 18 +
 rtl/program_sequencer_watchdog_counter.sv | 36 +++
 rtl/program_sequencer.sv | 121 ++++++++++++
 tb/tb_program_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared constants and state encoding for the program sequencer.
package program_sequencer_pkg;

  localparam int unsigned OPCODE_HALT     = 0;
  localparam int unsigned OPCODE_PLOT     = 1;
  localparam int unsigned PROG_ADDR_WIDTH = 8;
  localparam int unsigned WATCHDOG_WIDTH  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StAck,
    StExec,
    StError
  } seq_state_e;

endpackage

// File: rtl/program_sequencer_watchdog_counter.sv
// Handshake watchdog: counts enabled cycles since the last clear.
module program_sequencer_watchdog_counter
  import program_sequencer_pkg::*;
#(
  parameter int unsigned Timeout = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [WATCHDOG_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Flag during the Timeout-th enabled cycle so the owner acts on that same edge.
  assign expired_o = enable_i && (count_q == WATCHDOG_WIDTH'(Timeout - 1));

endmodule

// File: rtl/program_sequencer.sv
// Fetches ROM words and issues them to the datapath over the start/finished handshake.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned OPCODE_WIDTH      = 4,
  parameter int unsigned ADDR_WIDTH        = PROG_ADDR_WIDTH,
  parameter int unsigned TIMEOUT           = 255
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         run,
  input  logic                         abort,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic                         start,
  input  logic                         finished,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [ADDR_WIDTH-1:0]        pc
);

  localparam logic [OPCODE_WIDTH-1:0] OpHalt = OPCODE_WIDTH'(OPCODE_HALT);

  seq_state_e                   state_q;
  logic [ADDR_WIDTH-1:0]        pc_q;
  logic [INSTRUCTION_WIDTH-1:0] instruction_q;
  logic                         start_q, done_q, error_q, abort_pend_q;
  logic                         wd_clear, wd_enable, wd_expired;
  logic [OPCODE_WIDTH-1:0]      opcode;

  assign opcode    = mem_data[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign wd_clear  = (state_q == StLoad);
  assign wd_enable = (state_q == StAck) || (state_q == StExec);

  program_sequencer_watchdog_counter #(
    .Timeout (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      instruction_q <= '0;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      abort_pend_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle, StError: begin
          if (run && !abort) begin
            pc_q    <= '0;
            error_q <= 1'b0;
            state_q <= StFetch;
          end
        end
        StFetch: state_q <= abort ? StIdle : StLoad;
        StLoad: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (opcode == OpHalt) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            instruction_q <= mem_data;
            start_q       <= 1'b1;
            abort_pend_q  <= 1'b0;
            state_q       <= StAck;
          end
        end
        StAck, StExec: begin
          if (abort) begin
            abort_pend_q <= 1'b1;
          end
          // A timeout always lands in ERROR, even with an abort pending.
          if (wd_expired) begin
            error_q      <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= StError;
          end else if (state_q == StAck) begin
            if (!finished) begin
              state_q <= StExec;
            end
          end else if (finished) begin
            if (abort_pend_q || abort) begin
              abort_pend_q <= 1'b0;
              state_q      <= StIdle;
            end else if (&pc_q) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              pc_q    <= pc_q + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instruction = instruction_q;
  assign start       = start_q;
  assign done        = done_q;
  assign error       = error_q;
  assign busy        = (state_q != StIdle) && (state_q != StError);

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: two sequencer instances, behavioural ROMs and datapath models.
module tb_program_sequencer;

  localparam int LAT = 3;
  localparam logic [31:0] W0 = 32'h100F_0305;
  localparam logic [31:0] W1 = 32'h100F_0306;
  localparam logic [31:0] WBAD = 32'h2000_0000;

  typedef enum logic [1:0] {EvStart, EvDone, EvError} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  ev_t sb_a[$];
  ev_t sb_b[$];

  // Instance A: 8-bit address space, short watchdog
  logic        run_a = 1'b0, abort_a = 1'b0, start_a, fin_a, busy_a, done_a, error_a;
  logic [7:0]  mem_addr_a, pc_a;
  logic [31:0] mem_data_a, instr_a;
  logic [31:0] rom_a [0:255];

  // Instance B: 2-bit address space
  logic        run_b = 1'b0, abort_b = 1'b0, start_b, fin_b, busy_b, done_b, error_b;
  logic [1:0]  mem_addr_b, pc_b;
  logic [31:0] mem_data_b, instr_b;
  logic [31:0] rom_b [0:3];

  program_sequencer #(
    .INSTRUCTION_WIDTH (32),
    .OPCODE_WIDTH      (4),
    .ADDR_WIDTH        (8),
    .TIMEOUT           (10)
  ) dut_a (
    .clock (clk), .resetn (rstn), .run (run_a), .abort (abort_a),
    .mem_addr (mem_addr_a), .mem_data (mem_data_a), .instruction (instr_a),
    .start (start_a), .finished (fin_a), .busy (busy_a), .done (done_a),
    .error (error_a), .pc (pc_a)
  );

  program_sequencer #(
    .INSTRUCTION_WIDTH (32),
    .OPCODE_WIDTH      (4),
    .ADDR_WIDTH        (2),
    .TIMEOUT           (255)
  ) dut_b (
    .clock (clk), .resetn (rstn), .run (run_b), .abort (abort_b),
    .mem_addr (mem_addr_b), .mem_data (mem_data_b), .instruction (instr_b),
    .start (start_b), .finished (fin_b), .busy (busy_b), .done (done_b),
    .error (error_b), .pc (pc_b)
  );

  always @(posedge clk) mem_data_a <= rom_a[mem_addr_a];
  always @(posedge clk) mem_data_b <= rom_b[mem_addr_b];

  // Datapath models: drop finished after start, raise it LAT+1 cycles later (opcode 1 only)
  logic        dp_flush_a = 1'b0;
  int          dcnt_a = 0, dcnt_b = 0, dp_n_a = 0, dp_n_b = 0;
  logic [15:0] dp_xy_a [0:15];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fin_a <= 1'b1; dcnt_a <= 0;
    end else if (dp_flush_a) begin
      fin_a <= 1'b1;
    end else if (start_a) begin
      fin_a <= 1'b0; dcnt_a <= LAT;
    end else if (!fin_a && instr_a[31:28] == 4'd1) begin
      if (dcnt_a == 0) begin
        fin_a <= 1'b1;
        dp_xy_a[dp_n_a[3:0]] <= instr_a[15:0];
        dp_n_a <= dp_n_a + 1;
      end else dcnt_a <= dcnt_a - 1;
    end
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fin_b <= 1'b1; dcnt_b <= 0;
    end else if (start_b) begin
      fin_b <= 1'b0; dcnt_b <= LAT;
    end else if (!fin_b) begin
      if (dcnt_b == 0) begin
        fin_b <= 1'b1; dp_n_b <= dp_n_b + 1;
      end else dcnt_b <= dcnt_b - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int unit, input ev_kind_e kind, input logic [31:0] val,
                        input string name);
    ev_t e;
    if ((unit == 0 && sb_a.size() == 0) || (unit == 1 && sb_b.size() == 0)) begin
      tests++; fails++;
      $display("FAIL %s: unexpected event with value %0h, required no event", name, val);
    end else begin
      if (unit == 0) e = sb_a.pop_front();
      else e = sb_b.pop_front();
      check({name, "_kind"}, 32'(kind), 32'(e.kind));
      check(name, val, e.val);
    end
  endtask

  // Monitor A
  int          starts_a = 0, dones_a = 0, busy_cyc_a = 0, done_cyc_a = 0, err_cyc_a = 0;
  int          start_cycs_a[$];
  logic        inflight_a = 1'b0, saw_low_a = 1'b0, stable_a = 1'b1, err_prev_a = 1'b0;
  logic [31:0] held_a = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      inflight_a = 1'b0; saw_low_a = 1'b0; err_prev_a = 1'b0;
    end else begin
      if (busy_a) busy_cyc_a++;
      if (start_a) begin
        starts_a++;
        start_cycs_a.push_back(cyc);
        held_a = instr_a; inflight_a = 1'b1; saw_low_a = 1'b0; stable_a = 1'b1;
        sb_pop(0, EvStart, instr_a, "a_start_instr");
      end else if (inflight_a) begin
        if (instr_a !== held_a) stable_a = 1'b0;
        if (!fin_a) saw_low_a = 1'b1;
        else if (saw_low_a) begin
          check("a_instr_stable", 32'(stable_a), 32'd1);
          inflight_a = 1'b0;
        end
      end
      if (done_a) begin
        dones_a++; done_cyc_a = cyc;
        sb_pop(0, EvDone, 32'(pc_a), "a_done_pc");
      end
      if (error_a && !err_prev_a) begin
        err_cyc_a = cyc;
        sb_pop(0, EvError, 32'(pc_a), "a_error_pc");
      end
      err_prev_a = error_a;
    end
  end

  // Monitor B
  int starts_b = 0, dones_b = 0;
  always @(negedge clk) begin
    if (rstn) begin
      if (start_b) begin
        starts_b++;
        sb_pop(1, EvStart, instr_b, "b_start_instr");
      end
      if (done_b) begin
        dones_b++;
        sb_pop(1, EvDone, 32'(pc_b), "b_done_pc");
      end
    end
  end

  task automatic push(input int unit, input ev_kind_e kind, input logic [31:0] val);
    ev_t e;
    e.kind = kind; e.val = val;
    if (unit == 0) sb_a.push_back(e);
    else sb_b.push_back(e);
  endtask

  task automatic pulse_run(input int unit, output int t0);
    @(posedge clk); #1;
    if (unit == 0) run_a = 1'b1;
    else run_b = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    run_a = 1'b0; run_b = 1'b0;
  endtask

  task automatic wait_done(input int unit, input int target, input string name);
    int n = 0;
    while (((unit == 0) ? dones_a : dones_b) < target && n < 200) begin
      @(posedge clk); n++;
    end
    check(name, ((unit == 0) ? dones_a : dones_b), target);
  endtask

  task automatic load_prog_a();
    foreach (rom_a[i]) rom_a[i] = 32'h0;
    rom_a[0] = W0; rom_a[1] = W1;
  endtask

  int t0, s0, d0, b0, n0;

  initial begin
    load_prog_a();
    for (int i = 0; i < 4; i++) rom_b[i] = 32'h100F_0000 | 32'(i);

    #2 rstn = 1'b0;
    #1;
    check("rst_start", 32'(start_a), 0);
    check("rst_instr", instr_a, 0);
    check("rst_mem_addr", 32'(mem_addr_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done_error", {done_a, error_a}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Two PLOTs then HALT
    push(0, EvStart, W0); push(0, EvStart, W1); push(0, EvDone, 32'd2);
    s0 = starts_a;
    pulse_run(0, t0);
    wait_done(0, 1, "prog_done_count");
    repeat (3) @(posedge clk);
    check("prog_starts", starts_a - s0, 2);
    check("prog_first_start_cyc", start_cycs_a[s0], t0 + 3);
    check("prog_final_pc", 32'(pc_a), 2);
    check("prog_dp_xy0", 32'(dp_xy_a[0]), 32'h0305);
    check("prog_dp_xy1", 32'(dp_xy_a[1]), 32'h0306);
    check("prog_sb_empty", sb_a.size(), 0);

    // HALT at address 0
    rom_a[0] = 32'h0;
    push(0, EvDone, 32'd0);
    s0 = starts_a; b0 = busy_cyc_a;
    pulse_run(0, t0);
    wait_done(0, 2, "halt_done_count");
    repeat (3) @(posedge clk);
    check("halt_done_cyc", done_cyc_a, t0 + 3);
    check("halt_busy_cycles", busy_cyc_a - b0, 2);
    check("halt_no_start", starts_a - s0, 0);

    // Datapath never finishes: watchdog
    rom_a[0] = WBAD;
    push(0, EvStart, WBAD); push(0, EvError, 32'd0);
    pulse_run(0, t0);
    n0 = 0;
    while (!error_a && n0 < 50) begin @(posedge clk); n0++; end
    #1;
    check("wd_error_cyc", err_cyc_a, t0 + 13);
    check("wd_busy", 32'(busy_a), 0);
    check("wd_error", 32'(error_a), 1);
    @(posedge clk); #1 dp_flush_a = 1'b1;
    @(posedge clk); #1 dp_flush_a = 1'b0;
    rom_a[0] = 32'h0;
    push(0, EvDone, 32'd0);
    pulse_run(0, t0);
    check("wd_error_cleared", 32'(error_a), 0);
    wait_done(0, 3, "wd_rerun_done_count");

    // run and abort together in IDLE
    s0 = starts_a; b0 = busy_cyc_a;
    @(posedge clk); #1 run_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1 run_a = 1'b0; abort_a = 1'b0;
    repeat (5) @(posedge clk);
    check("abort_run_busy", busy_cyc_a - b0, 0);
    check("abort_run_start", starts_a - s0, 0);

    // Abort in first EXEC cycle of instruction 0
    load_prog_a();
    push(0, EvStart, W0);
    s0 = starts_a; d0 = dones_a; n0 = dp_n_a;
    pulse_run(0, t0);
    repeat (4) @(posedge clk);
    #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_starts", starts_a - s0, 1);
    check("abort_no_done", dones_a - d0, 0);
    check("abort_handshake_done", dp_n_a - n0, 1);
    check("abort_idle", {busy_a, 7'(pc_a)}, 0);
    check("abort_sb_empty", sb_a.size(), 0);

    // Reset while in EXEC
    push(0, EvStart, W0);
    pulse_run(0, t0);
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_start_busy", {start_a, busy_a, done_a, error_a}, 0);
    check("mid_rst_instr", instr_a, 0);
    check("mid_rst_pc_addr", {pc_a, mem_addr_a}, 0);
    @(posedge clk); #1 rstn = 1'b1;
    push(0, EvStart, W0); push(0, EvStart, W1); push(0, EvDone, 32'd2);
    d0 = dones_a;
    pulse_run(0, t0);
    check("restart_pc", {pc_a, mem_addr_a}, 0);
    wait_done(0, d0 + 1, "restart_done_count");
    repeat (3) @(posedge clk);
    check("restart_sb_empty", sb_a.size(), 0);

    // 2-bit address space, all PLOT: four issues, no wrap
    for (int i = 0; i < 4; i++) push(1, EvStart, 32'h100F_0000 | 32'(i));
    push(1, EvDone, 32'd3);
    pulse_run(1, t0);
    wait_done(1, 1, "b_done_count");
    repeat (8) @(posedge clk);
    #1;
    check("b_starts", starts_b, 4);
    check("b_pc_no_wrap", {30'd0, pc_b}, 3);
    check("b_idle", {busy_b, error_b}, 0);
    check("b_dp_completions", dp_n_b, 4);
    check("b_sb_empty", sb_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
